// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the system bus arbiter.
package bus_arbiter_pkg;

    localparam int BUS_WIDTH = 38;
    localparam int CLC_WIDTH = 6;
    localparam int NUM_REQ   = 4;
    localparam int MAX_SKIP  = 4;

    // Request class encodings carried on bus_req_type
    localparam logic REQ_HIGH = 1'b1;
    localparam logic REQ_LOW  = 1'b0;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of vec at or
// after ptr, wrapping, as both a one-hot vector and an index.
module bus_arbiter_rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]  vec,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] index,
    output logic          valid
);

    localparam logic [2*N-1:0] ONE2 = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] dbl_s;
    logic [2*N-1:0] keep_s;
    logic [2*N-1:0] masked_s;
    logic [2*N-1:0] first_s;

    // Doubled-vector mask: clearing the lower copy below ptr makes the lowest
    // remaining set bit the round-robin winner; the upper copy covers the wrap.
    always_comb begin
        dbl_s    = {vec, vec};
        keep_s   = ~((ONE2 << ptr) - ONE2);
        masked_s = dbl_s & keep_s;
        first_s  = masked_s & (~masked_s + ONE2);
        winner   = first_s[N-1:0] | first_s[2*N-1:N];
        valid    = |vec;
    end

    // Encode the one-hot winner into an index (zero when nothing is set)
    always_comb begin
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (winner[i]) begin
                index = PW'(i);
            end else begin
                index = index;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared tri-state system bus. Two priority classes,
// round-robin within a class via one shared pointer, a skip counter that lets
// a starving low-class request through, exact tenures and one dead cycle
// between owners so that tri-state drivers never overlap.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = bus_arbiter_pkg::NUM_REQ,
    parameter  int CLC_WIDTH = bus_arbiter_pkg::CLC_WIDTH,
    parameter  int MAX_SKIP  = bus_arbiter_pkg::MAX_SKIP,
    localparam int OWNER_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic                           plusclk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             bus_req,
    input  logic [NUM_REQ-1:0]             bus_req_type,
    input  logic [NUM_REQ*CLC_WIDTH-1:0]   bus_req_clc,
    output logic [NUM_REQ-1:0]             bus_grant,
    output logic                           bus_active,
    output logic [OWNER_W-1:0]             bus_owner
);

    localparam int SKIP_W = $clog2(MAX_SKIP + 1);

    localparam logic [SKIP_W-1:0]    SKIP_MAX  = SKIP_W'(MAX_SKIP);
    localparam logic [SKIP_W-1:0]    SKIP_ONE  = SKIP_W'(1);
    localparam logic [OWNER_W-1:0]   LAST_IDX  = OWNER_W'(NUM_REQ - 1);
    localparam logic [OWNER_W-1:0]   OWNER_ONE = OWNER_W'(1);
    localparam logic [CLC_WIDTH-1:0] CLC_ONE   = CLC_WIDTH'(1);

    arb_state_e             state_r;
    logic [NUM_REQ-1:0]     grant_r;
    logic                   active_r;
    logic [OWNER_W-1:0]     owner_r;
    logic [OWNER_W-1:0]     rr_ptr_r;
    logic [SKIP_W-1:0]      skip_r;
    logic [CLC_WIDTH-1:0]   cnt_r;

    logic [NUM_REQ-1:0]     high_s;
    logic [NUM_REQ-1:0]     low_s;
    logic [NUM_REQ-1:0]     high_win_s;
    logic [NUM_REQ-1:0]     low_win_s;
    logic [NUM_REQ-1:0]     win_s;
    logic [OWNER_W-1:0]     high_idx_s;
    logic [OWNER_W-1:0]     low_idx_s;
    logic [OWNER_W-1:0]     win_idx_s;
    logic [OWNER_W-1:0]     next_ptr_s;
    logic                   high_vld_s;
    logic                   low_vld_s;
    logic                   win_vld_s;
    logic                   pick_low_s;
    logic [CLC_WIDTH-1:0]   win_clc_s;
    logic [CLC_WIDTH-1:0]   load_cnt_s;
    logic [SKIP_W-1:0]      next_skip_s;

    // Split pending requests into the high and low candidate sets
    always_comb begin
        high_s = '0;
        low_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            high_s[i] = bus_req[i] && (bus_req_type[i] == REQ_HIGH);
            low_s[i]  = bus_req[i] && (bus_req_type[i] == REQ_LOW);
        end
    end

    bus_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_high (
        .vec    (high_s),
        .ptr    (rr_ptr_r),
        .winner (high_win_s),
        .index  (high_idx_s),
        .valid  (high_vld_s)
    );

    bus_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_low (
        .vec    (low_s),
        .ptr    (rr_ptr_r),
        .winner (low_win_s),
        .index  (low_idx_s),
        .valid  (low_vld_s)
    );

    // Choose the class: low wins when it has been skipped too often or when
    // no high request is pending; also derive pointer and skip updates.
    always_comb begin
        if (low_vld_s && ((skip_r == SKIP_MAX) || !high_vld_s)) begin
            pick_low_s = 1'b1;
        end else begin
            pick_low_s = 1'b0;
        end

        if (pick_low_s) begin
            win_s     = low_win_s;
            win_idx_s = low_idx_s;
        end else begin
            win_s     = high_win_s;
            win_idx_s = high_idx_s;
        end

        win_vld_s = high_vld_s | low_vld_s;

        if (win_idx_s == LAST_IDX) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_idx_s + OWNER_ONE;
        end

        if (low_vld_s && !pick_low_s) begin
            if (skip_r == SKIP_MAX) begin
                next_skip_s = skip_r;
            end else begin
                next_skip_s = skip_r + SKIP_ONE;
            end
        end else begin
            next_skip_s = '0;
        end
    end

    // Fetch the winner's tenure and turn it into the grant-hold count
    always_comb begin
        win_clc_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == OWNER_W'(i)) begin
                win_clc_s = bus_req_clc[i*CLC_WIDTH +: CLC_WIDTH];
            end else begin
                win_clc_s = win_clc_s;
            end
        end
        // A zero tenure still yields one grant cycle
        if (win_clc_s == '0) begin
            load_cnt_s = '0;
        end else begin
            load_cnt_s = win_clc_s - CLC_ONE;
        end
    end

    // Arbiter FSM: arbitrate in IDLE/TURN, hold the grant for the full
    // tenure, then spend one dead cycle in TURN before the next owner.
    always_ff @(posedge plusclk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            active_r <= 1'b0;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            skip_r   <= '0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_TURN: begin
                    if (win_vld_s) begin
                        state_r  <= ST_GRANT;
                        grant_r  <= win_s;
                        active_r <= 1'b1;
                        owner_r  <= win_idx_s;
                        rr_ptr_r <= next_ptr_s;
                        skip_r   <= next_skip_s;
                        cnt_r    <= load_cnt_s;
                    end else begin
                        state_r  <= ST_IDLE;
                        grant_r  <= '0;
                        active_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CLC_ONE;
                    end else begin
                        state_r  <= ST_TURN;
                        grant_r  <= '0;
                        active_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= '0;
                    active_r <= 1'b0;
                    cnt_r    <= '0;
                end
            endcase
        end
    end

    assign bus_grant  = grant_r;
    assign bus_active = active_r;
    assign bus_owner  = owner_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a tenure-level model.
module tb_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int CW       = 6;
    localparam int MAXSKIP  = 4;

    logic              plusclk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   typ;
    logic [NREQ*CW-1:0] clc;
    logic [NREQ-1:0]   grant;
    logic              active;
    logic [1:0]        owner;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining grant cycles of the current tenure
    int m_remain = 0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_skip   = 0;

    typedef struct {
        logic            rst;
        logic [3:0]      req;
        logic [3:0]      typ;
        logic [23:0]     clc;
        logic [3:0]      grant;
        logic            active;
        logic [1:0]      owner;
    } vec_t;

    vec_t tq[$];

    bus_arbiter dut (
        .plusclk      (plusclk),
        .rst          (rst),
        .bus_req      (req),
        .bus_req_type (typ),
        .bus_req_clc  (clc),
        .bus_grant    (grant),
        .bus_active   (active),
        .bus_owner    (owner)
    );

    initial plusclk = 1'b0;
    always #5 plusclk = ~plusclk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] t,
                                input logic [23:0] c, input logic [3:0] g,
                                input logic a, input logic [1:0] o);
        vec_t v;
        v.rst = r; v.req = q; v.typ = t; v.clc = c;
        v.grant = g; v.active = a; v.owner = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] g, input logic a, input logic [1:0] o);
        chk({name, ".grant"}, 32'(grant), 32'(g));
        chk({name, ".active"}, 32'(active), 32'(a));
        chk({name, ".owner"}, 32'(owner), 32'(o));
    endtask

    // Model update at an edge: arbitrate only when no tenure is running
    task automatic model_edge();
        int h, l, cand, win, c;
        bit use_l;
        if (rst) begin
            m_remain = 0; m_owner = 0; m_ptr = 0; m_skip = 0;
        end else if (m_remain > 0) begin
            m_remain = m_remain - 1;
        end else if (req != 4'b0000) begin
            h = int'(req & typ);
            l = int'(req & ~typ);
            use_l = ((m_skip == MAXSKIP) && (l != 0)) || (h == 0);
            cand = use_l ? l : h;
            win = 0;
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (cand[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
            if (l != 0 && !use_l) m_skip = (m_skip + 1 > MAXSKIP) ? MAXSKIP : m_skip + 1;
            else m_skip = 0;
            c = int'(clc[win*CW +: CW]);
            m_remain = (c == 0) ? 1 : c;
            m_owner = win;
            m_ptr = (win + 1) % NREQ;
        end
    endtask

    task automatic step();
        @(posedge plusclk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; typ = 4'b0000; clc = 24'd0;
        step();
        rst = 1'b0;
    endtask

    localparam logic [23:0] ALL1 = {6'd1, 6'd1, 6'd1, 6'd1};
    localparam logic [23:0] ALL2 = {6'd2, 6'd2, 6'd2, 6'd2};

    initial begin
        logic [3:0] mg;
        rst = 1'b1; req = 4'b0000; typ = 4'b0000; clc = 24'd0;

        // Reset for 3 cycles, then 10 idle cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset", 4'b0000, 1'b0, 2'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out("idle", 4'b0000, 1'b0, 2'd0);
        end

        // Vector table: single request clc=6, clc=0, reset vs request, round-robin
        tq.push_back(mk(1'b0, 4'b0001, 4'b0000, 24'd6, 4'b0001, 1'b1, 2'd0));
        for (int i = 0; i < 5; i++)
            tq.push_back(mk(1'b0, 4'b0000, 4'b0000, 24'd6, 4'b0001, 1'b1, 2'd0));
        tq.push_back(mk(1'b0, 4'b0000, 4'b0000, 24'd6, 4'b0000, 1'b0, 2'd0));
        tq.push_back(mk(1'b0, 4'b0000, 4'b0000, 24'd6, 4'b0000, 1'b0, 2'd0));
        tq.push_back(mk(1'b0, 4'b0001, 4'b0000, 24'd0, 4'b0001, 1'b1, 2'd0));
        tq.push_back(mk(1'b0, 4'b0000, 4'b0000, 24'd0, 4'b0000, 1'b0, 2'd0));
        tq.push_back(mk(1'b0, 4'b0000, 4'b0000, 24'd0, 4'b0000, 1'b0, 2'd0));
        tq.push_back(mk(1'b1, 4'b1111, 4'b0000, ALL1,  4'b0000, 1'b0, 2'd0));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0001, 1'b1, 2'd0));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0000, 1'b0, 2'd0));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0010, 1'b1, 2'd1));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0000, 1'b0, 2'd1));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0100, 1'b1, 2'd2));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0000, 1'b0, 2'd2));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b1000, 1'b1, 2'd3));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0000, 1'b0, 2'd3));
        tq.push_back(mk(1'b0, 4'b1111, 4'b0000, ALL1,  4'b0001, 1'b1, 2'd0));
        tq.push_back(mk(1'b0, 4'b0000, 4'b0000, ALL1,  4'b0000, 1'b0, 2'd0));
        tq.push_back(mk(1'b0, 4'b0000, 4'b0000, ALL1,  4'b0000, 1'b0, 2'd0));

        for (int i = 0; i < tq.size(); i++) begin
            rst = tq[i].rst; req = tq[i].req; typ = tq[i].typ; clc = tq[i].clc;
            step();
            chk_out($sformatf("vec%0d", i), tq[i].grant, tq[i].active, tq[i].owner);
        end

        // Priority: high req2 beats low req0; req0 gets the grant after TURN
        do_reset();
        req = 4'b0101; typ = 4'b0100; clc = ALL2;
        step(); chk_out("prio.g2a", 4'b0100, 1'b1, 2'd2);
        req = 4'b0001;
        step(); chk_out("prio.g2b", 4'b0100, 1'b1, 2'd2);
        step(); chk_out("prio.turn", 4'b0000, 1'b0, 2'd2);
        step(); chk_out("prio.g0a", 4'b0001, 1'b1, 2'd0);
        req = 4'b0000;
        step(); chk_out("prio.g0b", 4'b0001, 1'b1, 2'd0);
        step(); chk_out("prio.end", 4'b0000, 1'b0, 2'd0);

        // Starvation: high req3 wins four times, then low req1, then repeat
        do_reset();
        req = 4'b1010; typ = 4'b1000; clc = ALL1;
        for (int a = 0; a < 10; a++) begin
            step();
            if (a % 5 == 4) chk_out($sformatf("starve%0d", a), 4'b0010, 1'b1, 2'd1);
            else            chk_out($sformatf("starve%0d", a), 4'b1000, 1'b1, 2'd3);
            step();
            chk("starve.gap", 32'(grant), 32'd0);
        end

        // Reset in the 5th grant cycle of a 20-cycle tenure
        do_reset();
        req = 4'b0001; typ = 4'b0000; clc = 24'd20;
        step(); chk_out("midrst.g1", 4'b0001, 1'b1, 2'd0);
        req = 4'b0000;
        for (int i = 2; i <= 5; i++) begin
            step(); chk_out($sformatf("midrst.g%0d", i), 4'b0001, 1'b1, 2'd0);
        end
        rst = 1'b1;
        step(); chk_out("midrst.rst", 4'b0000, 1'b0, 2'd0);
        rst = 1'b0; req = 4'b1111; clc = ALL1;
        step(); chk_out("midrst.ptr0", 4'b0001, 1'b1, 2'd0);
        req = 4'b0000;
        step(); chk_out("midrst.turn", 4'b0000, 1'b0, 2'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            req = 4'($urandom_range(0, 15));
            typ = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) clc[i*CW +: CW] = 6'($urandom_range(0, 5));
            step();
            mg = (m_remain > 0) ? 4'(1 << m_owner) : 4'b0000;
            chk_out("rand", mg, (m_remain > 0), 2'(m_owner));
            chk("rand.onehot", 32'($onehot0(grant)), 32'd1);
            chk("rand.active_or", 32'(active), 32'(|grant));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
